// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Purpose
//   Takes results from the execute stage, buffers the register-writing ones in
//   a 2-entry in-order FIFO and drives them into the register file through a
//   four-phase store sequence:
//     IDLE -> SETUP -> STROBE -> RELEASE -> IDLE
//   dest_reg/dest_val are loaded when IDLE hands off to SETUP and then held,
//   so they are stable a full cycle before store_now rises. store_now is high
//   only in STROBE. The head entry is popped, and retire_cnt bumped, when
//   RELEASE returns to IDLE. Results with in_wen=0 are never queued; they
//   retire in the cycle they are accepted.
//
// Configuration
//   WB_FWD_EN : when defined, fwd_hit/fwd_val search the valid FIFO entries
//               (youngest first, including the one currently being stored).
//               When undefined, fwd_hit/fwd_val are tied to zero.
//
// Handshake
//   Input side is valid/ready: a result transfers on a posedge where
//   in_valid & in_ready. in_ready depends only on the registered occupancy, so
//   a full FIFO refuses input even in the cycle it pops. store_done is
//   level-sampled at each posedge while in STROBE.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready input handshake
//   in_wen            1 = result writes a register, 0 = retire without write
//   in_dest, in_val   destination index and value
//   dest_reg/dest_val register-file write index and data
//   store_now         register-file store strobe (file writes on rising edge)
//   store_done        register-file store acknowledge
//   busy              FIFO non-empty or sequencer not idle
//   retire_cnt        wrapping count of retired results
//   fwd_src           forwarding query index
//   fwd_hit/fwd_val   youngest pending write to fwd_src
//   dbgState          current sequencer state, for observation
// -----------------------------------------------------------------------------
module writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [3:0]  in_dest,
  input  logic [15:0] in_val,
  output logic [3:0]  dest_reg,
  output logic [15:0] dest_val,
  output logic        store_now,
  input  logic        store_done,
  output logic        busy,
  output logic [7:0]  retire_cnt,
  input  logic [3:0]  fwd_src,
  output logic        fwd_hit,
  output logic [15:0] fwd_val,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } wbState_t;

  wbState_t state;
  wbState_t stateNext;

  // FIFO storage: two slots addressed by a 1-bit read pointer and a count.
  logic [3:0]  fifoDest [2];
  logic [15:0] fifoVal  [2];
  logic        rdPtr;
  logic        wrPtr;
  logic [1:0]  count;

  logic        accept;
  logic        push;
  logic        pop;
  logic        retireNow;
  logic        loadHead;

  // Only the registered count is used, so a same-cycle pop never opens a slot.
  assign in_ready  = (count != 2'd2);
  assign accept    = in_valid & in_ready;
  assign push      = accept & in_wen;
  assign retireNow = accept & ~in_wen;
  // RELEASE always lasts exactly one cycle and pops on its way out.
  assign pop       = (state == RELEASE);

  // Pushes only happen with count 0 or 1, so the tail is rdPtr offset by count.
  assign wrPtr     = rdPtr ^ count[0];

  assign busy      = (count != 2'd0) | (state != IDLE);
  assign store_now = (state == STROBE);
  assign dbgState  = state;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    loadHead  = 1'b0;
    case (state)
      IDLE: begin
        if (count != 2'd0) begin
          stateNext = SETUP;
          loadHead  = 1'b1;
        end
      end
      SETUP: begin
        stateNext = STROBE;
      end
      STROBE: begin
        if (store_done) begin
          stateNext = RELEASE;
        end
      end
      RELEASE: begin
        // store_done may still be high here; it is ignored outside STROBE.
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifoDest[0] <= 4'd0;
      fifoDest[1] <= 4'd0;
      fifoVal[0]  <= 16'd0;
      fifoVal[1]  <= 16'd0;
      rdPtr       <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifoDest[wrPtr] <= in_dest;
        fifoVal[wrPtr]  <= in_val;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file write port: captured once at the start of a store so the
  // index and data cannot move while the sequence is in progress.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_reg <= 4'd0;
      dest_val <= 16'd0;
    end else if (loadHead) begin
      dest_reg <= fifoDest[rdPtr];
      dest_val <= fifoVal[rdPtr];
    end
  end

  // ---------------------------------------------------------------------------
  // Retire counter: a pop and a no-write retire can land together (+2).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= 8'd0;
    end else begin
      retire_cnt <= retire_cnt + {7'd0, retireNow} + {7'd0, pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
`ifdef WB_FWD_EN
  logic youngValid;
  logic oldValid;

  // With two entries the younger one sits opposite the read pointer; with one
  // entry only the head is valid. The head stays valid while it is stored.
  assign youngValid = (count == 2'd2);
  assign oldValid   = (count != 2'd0);

  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = 16'd0;
    if (youngValid && (fifoDest[~rdPtr] == fwd_src)) begin
      fwd_hit = 1'b1;
      fwd_val = fifoVal[~rdPtr];
    end else if (oldValid && (fifoDest[rdPtr] == fwd_src)) begin
      fwd_hit = 1'b1;
      fwd_val = fifoVal[rdPtr];
    end
  end
`else
  logic unusedFwdSrc;

  assign unusedFwdSrc = ^fwd_src;
  assign fwd_hit      = 1'b0;
  assign fwd_val      = 16'd0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//
// Self-checking bench for writeback_unit. Every cycle goes through the cycle
// task, which drives inputs, steps one clock and compares the DUT against a
// queue-based reference: the queue holds the writes that are accepted but not
// yet retired, in order. The store handshake (store_now/store_done) decides
// when the head leaves the queue. Directed scenarios come first, then a
// randomized run, all in one initial block. Define WB_FWD_EN for both files to
// exercise forwarding.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

`ifdef WB_FWD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        inValid = 1'b0;
  logic        inReady;
  logic        inWen = 1'b0;
  logic [3:0]  inDest = 4'd0;
  logic [15:0] inVal = 16'd0;
  logic [3:0]  destReg;
  logic [15:0] destVal;
  logic        storeNow;
  logic        storeDone = 1'b0;
  logic        busy;
  logic [7:0]  retireCnt;
  logic [3:0]  fwdSrc = 4'd0;
  logic        fwdHit;
  logic [15:0] fwdVal;
  logic [1:0]  dbgState;

  writeback_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_wen     (inWen),
    .in_dest    (inDest),
    .in_val     (inVal),
    .dest_reg   (destReg),
    .dest_val   (destVal),
    .store_now  (storeNow),
    .store_done (storeDone),
    .busy       (busy),
    .retire_cnt (retireCnt),
    .fwd_src    (fwdSrc),
    .fwd_hit    (fwdHit),
    .fwd_val    (fwdVal),
    .dbgState   (dbgState)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference state
  // ---------------------------------------------------------------------------
  logic [19:0] exp_q[$];      // pending writes {dest, val}, oldest first
  logic [19:0] storeLog[$];   // writes seen at store_now rising edges
  logic [7:0]  retireExp;
  bit          popPending;
  logic        prevStoreNow;
  logic [3:0]  prevDest;
  logic [15:0] prevVal;
  int          strobeAge;
  int          sdMode;        // 0 tied 1, 1 after 3 strobe cycles, 2 random, 3 never
  int          riseCount;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to src, as {hit, value}.
  function automatic logic [16:0] fwdModel(input logic [3:0] src);
    logic [16:0] r;
    r = 17'd0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][19:16] == src) begin
        r = {1'b1, exp_q[i][15:0]};
        break;
      end
    end
    return FwdOn ? r : 17'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle with full reference comparison
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic v, input logic wen, input logic [3:0] d,
                       input logic [15:0] val, output bit accepted);
    bit          sd;
    bit          acc;
    logic [16:0] f;
    case (sdMode)
      0:       sd = 1'b1;
      1:       sd = storeNow && (strobeAge >= 3);
      2:       sd = ($urandom_range(0, 2) != 0);
      default: sd = 1'b0;
    endcase
    inValid   = v;
    inWen     = wen;
    inDest    = d;
    inVal     = val;
    storeDone = sd;
    acc       = v && inReady;
    @(posedge clk);
    #1;
    // Reference update for the edge just taken: pop first, then accept.
    if (popPending) begin
      popPending = 1'b0;
      retireExp++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (acc && wen) exp_q.push_back({d, val});
    if (acc && !wen) retireExp++;
    // Store protocol.
    if (prevStoreNow) begin
      check("strobe_exit_on_done", storeNow, !sd);
      if (storeNow) check("strobe_data_stable", {destReg, destVal}, {prevDest, prevVal});
      else popPending = 1'b1;
    end else if (storeNow) begin
      riseCount++;
      if (exp_q.size() == 0) begin
        check("store_with_empty_queue", storeNow, 1'b0);
      end else begin
        check("store_head", {destReg, destVal}, exp_q[0]);
        check("store_setup_stable", {destReg, destVal}, {prevDest, prevVal});
      end
      storeLog.push_back({destReg, destVal});
    end
    check("in_ready", inReady, exp_q.size() < 2);
    check("busy", busy, exp_q.size() != 0);
    check("retire_cnt", retireCnt, retireExp);
    f = fwdModel(fwdSrc);
    check("fwd", {fwdHit, fwdVal}, f);
    strobeAge    = storeNow ? strobeAge + 1 : 0;
    prevStoreNow = storeNow;
    prevDest     = destReg;
    prevVal      = destVal;
    accepted     = acc;
  endtask

  task automatic doReset();
    inValid   = 1'b0;
    inWen     = 1'b0;
    inDest    = 4'd0;
    inVal     = 16'd0;
    storeDone = 1'b0;
    rst       = 1'b1;
    #1;
    check("rst_store_now", storeNow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", inReady, 1'b1);
    check("rst_retire_cnt", retireCnt, 8'd0);
    check("rst_dest_reg", destReg, 4'd0);
    check("rst_dest_val", destVal, 16'd0);
    check("rst_fwd", {fwdHit, fwdVal}, 17'd0);
    exp_q.delete();
    retireExp    = 8'd0;
    popPending   = 1'b0;
    prevStoreNow = 1'b0;
    prevDest     = 4'd0;
    prevVal      = 16'd0;
    strobeAge    = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      cycle(1'b0, 1'b0, 4'd0, 16'd0, a);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy", busy, 1'b0);
  endtask

  // Watchdog: the run must end by itself even if the DUT wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed steps, then randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    bit a;
    int n;
    int rises;
    riseCount = 0;
    sdMode    = 0;

    // Reset state.
    doReset();

    // Single write into an empty unit, store_done tied high.
    cycle(1'b1, 1'b1, 4'd3, 16'h1234, a);                 // edge N
    check("t1_accept", a, 1'b1);
    check("t1_n_store_now", storeNow, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 16'd0, a);                    // N+1: SETUP
    check("t1_n1_store_now", storeNow, 1'b0);
    check("t1_n1_dest", {destReg, destVal}, {4'd3, 16'h1234});
    cycle(1'b0, 1'b0, 4'd0, 16'd0, a);                    // N+2: STROBE
    check("t1_n2_store_now", storeNow, 1'b1);
    check("t1_n2_dest", {destReg, destVal}, {4'd3, 16'h1234});
    cycle(1'b0, 1'b0, 4'd0, 16'd0, a);                    // N+3: RELEASE
    check("t1_n3_store_now", storeNow, 1'b0);
    check("t1_n3_retire", retireCnt, 8'd0);
    cycle(1'b0, 1'b0, 4'd0, 16'd0, a);                    // N+4: popped
    check("t1_n4_retire", retireCnt, 8'd1);
    check("t1_n4_busy", busy, 1'b0);

    // Three back-to-back writes with a slow acknowledge.
    sdMode = 1;
    storeLog.delete();
    rises = riseCount;
    cycle(1'b1, 1'b1, 4'd1, 16'h0001, a);
    check("t2_ready_after_first", inReady, 1'b1);
    cycle(1'b1, 1'b1, 4'd2, 16'h0002, a);
    check("t2_ready_after_second", inReady, 1'b0);
    cycle(1'b1, 1'b1, 4'd3, 16'h0003, a);
    check("t2_full_refuses", a, 1'b0);
    n = 0;
    while (!a && n < 50) begin
      cycle(1'b1, 1'b1, 4'd3, 16'h0003, a);
      n++;
    end
    check("t2_third_accepted", a, 1'b1);
    drain();
    check("t2_store_count", riseCount - rises, 3);
    check("t2_log_size", storeLog.size(), 3);
    if (storeLog.size() == 3) begin
      check("t2_store0", storeLog[0], {4'd1, 16'h0001});
      check("t2_store1", storeLog[1], {4'd2, 16'h0002});
      check("t2_store2", storeLog[2], {4'd3, 16'h0003});
    end

    // Coincident pop and no-write retire, across the 8-bit wrap.
    sdMode = 0;
    doReset();
    for (int i = 0; i < 254; i++) cycle(1'b1, 1'b0, 4'd0, 16'd0, a);
    check("t3_retire_254", retireCnt, 8'd254);
    cycle(1'b1, 1'b1, 4'd7, 16'h0777, a);                 // edge N
    cycle(1'b0, 1'b0, 4'd0, 16'd0, a);                    // SETUP
    cycle(1'b0, 1'b0, 4'd0, 16'd0, a);                    // STROBE
    cycle(1'b0, 1'b0, 4'd0, 16'd0, a);                    // RELEASE
    check("t3_release_retire", retireCnt, 8'd254);
    check("t3_release_store_now", storeNow, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 16'd0, a);                    // pop + retire
    check("t3_coincident_accept", a, 1'b1);
    check("t3_retire_wrap", retireCnt, 8'd0);

    // Reset in the middle of a store.
    sdMode = 3;
    cycle(1'b1, 1'b0, 4'd0, 16'd0, a);
    cycle(1'b1, 1'b1, 4'd4, 16'h4444, a);
    cycle(1'b1, 1'b1, 4'd8, 16'h8888, a);
    n = 0;
    while (!storeNow && n < 10) begin
      cycle(1'b0, 1'b0, 4'd0, 16'd0, a);
      n++;
    end
    check("t4_in_strobe", storeNow, 1'b1);
    check("t4_retire_before", retireCnt, 8'd1);
    #3;
    doReset();
    sdMode = 0;
    rises  = riseCount;
    cycle(1'b1, 1'b0, 4'd0, 16'd0, a);
    check("t4_accept_after_reset", a, 1'b1);
    check("t4_retire_after_reset", retireCnt, 8'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 4'd0, 16'd0, a);
    check("t4_no_replay", riseCount - rises, 0);

    // Forwarding: two writes to the same register, youngest wins.
    sdMode = 3;
    fwdSrc = 4'd5;
    cycle(1'b1, 1'b1, 4'd5, 16'h00AA, a);
    check("t5_fwd_one_hit", fwdHit, FwdOn);
    check("t5_fwd_one_val", fwdVal, FwdOn ? 16'h00AA : 16'h0000);
    cycle(1'b1, 1'b1, 4'd5, 16'h00BB, a);
    check("t5_fwd_two_hit", fwdHit, FwdOn);
    check("t5_fwd_two_val", fwdVal, FwdOn ? 16'h00BB : 16'h0000);
    fwdSrc = 4'd6;
    cycle(1'b0, 1'b0, 4'd0, 16'd0, a);
    check("t5_fwd_other_reg", fwdHit, 1'b0);
    fwdSrc = 4'd5;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'd0, 16'd0, a);
    check("t5_strobing", storeNow, 1'b1);
    check("t5_fwd_during_strobe", fwdVal, FwdOn ? 16'h00BB : 16'h0000);
    sdMode = 0;
    drain();
    check("t5_fwd_after_pops", fwdHit, 1'b0);

    // Randomized traffic with a random acknowledge.
    sdMode = 2;
    for (int i = 0; i < 1500; i++) begin
      fwdSrc = 4'($urandom_range(0, 5));
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
            4'($urandom_range(0, 5)), 16'($urandom()), a);
    end
    sdMode = 0;
    drain();
    check("rand_final_retire", retireCnt, retireExp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on posedge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  execute stage presents a result.
REQ-004 SHALL have port: in_ready  output  1  unit can accept a result this cycle.
REQ-005 SHALL have port: in_wen  input  1  result writes a register (0 = retire without write).
REQ-006 SHALL have port: in_dest  input  4  destination register index.
REQ-007 SHALL have port: in_val  input  16  result value.
REQ-008 SHALL have port: dest_reg  output  4  register-file write index.
REQ-009 SHALL have port: dest_val  output  16  register-file write data.
REQ-010 SHALL have port: store_now  output  1  register-file store strobe; the register file writes on its rising edge.
REQ-011 SHALL have port: store_done  input  1  register-file store acknowledge, level-sampled.
REQ-012 SHALL have port: busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-013 SHALL have port: retire_cnt  output  8  count of retired results, wraps.
REQ-014 SHALL have port: fwd_src  input  4  forwarding query index.
REQ-015 SHALL have port: fwd_hit  output  1  pending write to fwd_src exists.
REQ-016 SHALL have port: fwd_val  output  16  value of the youngest pending write to fwd_src.

Function
REQ-017 SHALL buffer writes in a 2-entry in-order FIFO; in_ready = (registered count < 2); accept = in_valid & in_ready at posedge.
REQ-018 SHALL NOT enqueue accepted results with in_wen=0; each one increments retire_cnt in the accept cycle.
REQ-019 SHALL NOT let in_ready count a same-cycle pop when full; a full FIFO refuses input for that cycle.
REQ-020 SHALL run the FSM IDLE->SETUP->STROBE->RELEASE->IDLE; IDLE leaves only when the FIFO is non-empty.
REQ-021 SHALL drive dest_reg/dest_val from the FIFO head in SETUP, STROBE and RELEASE, and hold them stable across all three states.
REQ-022 SHALL keep store_now=0 in IDLE, SETUP and RELEASE and store_now=1 in STROBE, so data is stable one full cycle before the rising edge.
REQ-023 SHALL stay in STROBE until store_done is sampled 1 at a posedge, then go to RELEASE; the minimum STROBE dwell is 1 cycle.
REQ-024 SHALL, on leaving RELEASE, pop the head and increment retire_cnt; minimum 4 cycles per write, no upper bound.
REQ-025 SHALL drop store_now in RELEASE even when store_done is still 1, since store_done may stay high between stores.
REQ-026 SHALL latch the entry when the FIFO is empty and in_wen=1 at edge N, enter SETUP at N+1 and raise store_now at N+2.
REQ-027 SHALL, when a RELEASE pop and an in_wen=0 retire coincide, add 2 to retire_cnt; 255 wraps modulo 256.
REQ-028 SHALL write entries with equal in_dest in acceptance order, so the last accepted value wins.
REQ-029 SHALL keep busy combinational: (count != 0) | (state != IDLE).

Reset
REQ-030 SHALL, on rst assertion, immediately clear the FIFO, go to IDLE and zero store_now, dest_reg, dest_val, retire_cnt, fwd_hit and fwd_val; in_ready=1 and busy=0.
REQ-031 SHALL abandon a store in flight when reset hits mid-operation; the entry is not retired and is not replayed.
REQ-032 SHALL accept input from the first posedge after rst deasserts.

Configuration
REQ-033 SHALL, with WB_FWD_EN defined, make fwd_hit/fwd_val combinational over valid FIFO entries, youngest match first, including the entry under STROBE.
REQ-034 SHALL, without WB_FWD_EN, keep the fwd_* ports present but tie fwd_hit=0 and fwd_val=0, with no compare logic.

Verification
REQ-035 SHALL cover: accept R3=0x1234 into an empty unit at edge N, store_done tied 1 -> SETUP at N+1, store_now rises at N+2 with dest_reg=3/dest_val=0x1234, retire_cnt=1 after RELEASE.
REQ-036 SHALL cover: three back-to-back writes R1=0x0001, R2=0x0002, R3=0x0003 with store_done delayed 3 cycles -> in_ready=0 after the second accept, stores in order 1,2,3, no store_now glitch.
REQ-037 SHALL cover: in_wen=0 accepted while a store is in RELEASE -> retire_cnt +2 that cycle; retire_cnt starting at 254 -> 0.
REQ-038 SHALL cover: rst asserted while store_now=1 -> store_now=0 immediately, FIFO empty, busy=0, retire_cnt=0.
REQ-039 SHALL cover: under WB_FWD_EN, queue R5=0x00AA then R5=0x00BB with fwd_src=5 -> fwd_hit=1, fwd_val=0x00BB; after both pops fwd_hit=0; without the macro fwd_hit stays 0.
